// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the default operand width.
package seq_restoring_divider_pkg;

    localparam int DIV_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage : seq_restoring_divider_pkg

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle of the sequential restoring divider. The master
// issues start with operands, the slave (the divider) returns status and
// registered results.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface : seq_restoring_divider_if

// File: rtl/seq_restoring_divider_cla_subtractor.sv
// Carry-look-ahead subtractor: Diff = A + ~B + 1. Built from 4-bit
// look-ahead groups with the group carries rippled between groups.
// Cout = 1 means A >= B (no borrow).
module cla_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Cout
);
    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] a_s;
    logic [PW-1:0] bn_s;
    logic [PW-1:0] p_s;
    logic [PW-1:0] g_s;
    logic [PW:0]   c_s;
    logic          unused_pad_s;

    // Pad to whole groups; the pad bits only feed carries above Cout.
    assign a_s  = PW'(A);
    assign bn_s = ~(PW'(B));
    assign p_s  = a_s ^ bn_s;
    assign g_s  = a_s & bn_s;
    assign c_s[0] = 1'b1;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int BASE = 4 * k;
        assign c_s[BASE+1] = g_s[BASE]
                           | (p_s[BASE] & c_s[BASE]);
        assign c_s[BASE+2] = g_s[BASE+1]
                           | (p_s[BASE+1] & g_s[BASE])
                           | (p_s[BASE+1] & p_s[BASE] & c_s[BASE]);
        assign c_s[BASE+3] = g_s[BASE+2]
                           | (p_s[BASE+2] & g_s[BASE+1])
                           | (p_s[BASE+2] & p_s[BASE+1] & g_s[BASE])
                           | (p_s[BASE+2] & p_s[BASE+1] & p_s[BASE] & c_s[BASE]);
        assign c_s[BASE+4] = g_s[BASE+3]
                           | (p_s[BASE+3] & g_s[BASE+2])
                           | (p_s[BASE+3] & p_s[BASE+2] & g_s[BASE+1])
                           | (p_s[BASE+3] & p_s[BASE+2] & p_s[BASE+1] & g_s[BASE])
                           | (p_s[BASE+3] & p_s[BASE+2] & p_s[BASE+1] & p_s[BASE] & c_s[BASE]);
    end

    assign Diff = p_s[WIDTH-1:0] ^ c_s[WIDTH-1:0];
    assign Cout = c_s[WIDTH];

    // Pad-group bits above WIDTH are structurally present but not needed.
    assign unused_pad_s = ^{c_s, p_s};
endmodule : cla_subtractor

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero is resolved one edge after capture so that done appears
// two edges after the accepted start.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave bus
);
    localparam int                CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic             zpend_q, zpend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, done_q;

    logic [WIDTH:0]   shift_p_s;
    logic [WIDTH:0]   trial_s;
    logic             no_borrow_s;
    logic [WIDTH:0]   step_p_s;
    logic [WIDTH-1:0] step_q_s;
    logic             unused_p_msb_s;

    // P stays below the divisor, so its MSB is always 0 before the shift.
    assign shift_p_s      = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign unused_p_msb_s = p_q[WIDTH];

    cla_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
        .A    (shift_p_s),
        .B    ({1'b0, divisor_q}),
        .Diff (trial_s),
        .Cout (no_borrow_s)
    );

    assign step_p_s = no_borrow_s ? trial_s : shift_p_s;
    assign step_q_s = {q_q[WIDTH-2:0], no_borrow_s};

    // Next-state, iteration and result-capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        dividend_d  = dividend_q;
        zpend_d     = zpend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (zpend_q) begin
                    state_d     = ST_DONE;
                    zpend_d     = 1'b0;
                    quotient_d  = {WIDTH{1'b1}};
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                end else if (bus.start) begin
                    dividend_d = bus.dividend;
                    divisor_d  = bus.divisor;
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        zpend_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = {CNT_W{1'b0}};
                        p_d     = {(WIDTH+1){1'b0}};
                        q_d     = bus.dividend;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                p_d = step_p_s;
                q_d = step_q_s;
                if (cnt_q == LAST) begin
                    state_d     = ST_DONE;
                    quotient_d  = step_q_s;
                    remainder_d = step_p_s[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            p_q         <= {(WIDTH+1){1'b0}};
            q_q         <= {WIDTH{1'b0}};
            divisor_q   <= {WIDTH{1'b0}};
            dividend_q  <= {WIDTH{1'b0}};
            zpend_q     <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            dividend_q  <= dividend_d;
            zpend_q     <= zpend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule : seq_restoring_divider

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Iterative unsigned restoring divider. It is the inverse operation of the team's carry-look-ahead adder datapath and reuses the same CLA structure as a subtractor (A + ~B + 1). It resolves one quotient bit per clock, with a start/busy/done handshake. It sits beside the adder blocks as the first multi-cycle arithmetic unit in the SD122 arithmetic set.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits; legal range 2..16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; captured on the accepted start
divisor  input  WIDTH  unsigned divisor; captured on the accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  registered flag; set when the captured divisor was 0

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; all internal registers = 0.
- FSM states:
  - IDLE: start=1 at an edge captures the operands. If divisor != 0, go to RUN with iteration count 0. If divisor == 0, go to DONE. start=0 stays in IDLE.
  - RUN: one iteration per edge. After iteration WIDTH-1 completes, go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Iteration step, with partial remainder P (WIDTH+1 bits) and quotient shift register Q (WIDTH bits):
  - Form {P,Q} shifted left by 1.
  - Compute trial = P_shifted - {1'b0, divisor} in a WIDTH+1 bit cla_subtractor.
  - If Cout=1 (no borrow): P = trial and Q[0] = 1.
  - Otherwise P is restored (keeps P_shifted) and Q[0] = 0.
- Latency: with start accepted at edge t0, done is high in the cycle after edge t0+WIDTH. With WIDTH=4, that is 5 edges from start. Divide by zero: done is high after edge t0+1.
- Result registers update only on entry to DONE:
  - Normal division: quotient = Q, remainder = P[WIDTH-1:0], div_by_zero = 0.
  - Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
  - All result outputs hold until the next entry to DONE.
- Handshake rules:
  - start in RUN or DONE is ignored; no queuing.
  - Operand changes after the accepted edge have no effect.
  - busy=1 exactly in RUN; done and busy are never both high.
- Reset mid-operation: immediately returns to IDLE with all outputs 0. Partial results are discarded, and no done is produced for the aborted request.
- Width rule: P never exceeds divisor-1 after a step, so the WIDTH+1 bit subtractor cannot overflow. The remainder is always < divisor.

Decomposition:
- Shared package/include (div_defs.vh): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Sub-module cla_subtractor (parameter WIDTH):
  - Structural, built from 4-bit carry-look-ahead groups chained with ripple between groups.
  - Operation: A + ~B with Cin=1.
  - Ports A, B, Diff, Cout; Cout=1 means no borrow.
  - Instantiated once, at width WIDTH+1.
- Top level holds the FSM, counter and datapath registers only.

Test Plan:
1. Reset, then dividend=4'd11, divisor=4'd3, start pulse -> busy high for 4 cycles; done pulse at edge 5; quotient=4'd3, remainder=4'd2, div_by_zero=0.
2. 15/1 -> quotient=15, remainder=0. 15/15 -> quotient=1, remainder=0. 5/7 -> quotient=0, remainder=5.
3. dividend=4'd9, divisor=0 -> no busy; done after 2 edges; quotient=4'b1111, remainder=4'd9, div_by_zero=1.
4. During RUN of 11/3, assert start with 15/1 and change the operand inputs -> still quotient=3, remainder=2. A second start in IDLE then yields quotient=15, remainder=0.
5. Assert rst between edges 2 and 3 of a RUN -> outputs 0 immediately and state IDLE. No done pulse follows. A fresh 6/4 then gives quotient=1, remainder=2.
6. Exhaustive loop over all 256 operand pairs (WIDTH=4) with back-to-back starts. Check quotient*divisor + remainder == dividend and remainder < divisor; divisor=0 cases as in scenario 3.
